// File: rtl/frame_scan_ctrl.sv
// Frame buffer scan sequencer: fetches top/bottom pixel pairs from frame RAM,
// hands them to the display PHY, then blanks, latches and displays each row pair.
module frame_scan_ctrl #(
    parameter int NUM_ROWS       = 32,
    parameter int NUM_COLS       = 64,
    parameter int RAM_LATENCY    = 2,
    parameter int BLANK_CYCLES   = 4,
    parameter int DISPLAY_CYCLES = 256,
    parameter int ROW_ADDR_W     = $clog2(NUM_ROWS/2)
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  enable_in,
    output logic                  ram_en_out,
    output logic [15:0]           ram_addr_out,
    input  logic [23:0]           ram_data_in,
    output logic                  phy_enable_out,
    input  logic                  phy_ready_in,
    output logic [23:0]           pixel_top_out,
    output logic [23:0]           pixel_bot_out,
    output logic                  latch_enable_out,
    output logic                  output_enable_out,
    output logic [ROW_ADDR_W-1:0] addr_out,
    output logic                  busy_out,
    output logic                  frame_done_out
);
    localparam int HALF    = NUM_ROWS / 2;
    localparam int COL_W   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int DLY_MAX = (DISPLAY_CYCLES > BLANK_CYCLES) ?
                             ((DISPLAY_CYCLES > RAM_LATENCY) ? DISPLAY_CYCLES : RAM_LATENCY) :
                             ((BLANK_CYCLES > RAM_LATENCY) ? BLANK_CYCLES : RAM_LATENCY);
    localparam int DLY_W   = $clog2(DLY_MAX + 3);

    typedef enum logic [3:0] {
        IDLE, FETCH_TOP, WAIT_TOP, FETCH_BOT, WAIT_BOT, SEND, WAIT_PHY,
        BLANK, LATCH, UNBLANK, DISPLAY
    } state_t;

    state_t                 state;
    logic [COL_W-1:0]       col;
    logic [ROW_ADDR_W-1:0]  row;
    logic [DLY_W-1:0]       dly;

    function automatic logic [15:0] pix_addr(input int r, input int c);
        int a;
        a = r * NUM_COLS + c;
        return a[15:0];
    endfunction

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state             <= IDLE;
            col               <= '0;
            row               <= '0;
            dly               <= '0;
            ram_en_out        <= 1'b0;
            ram_addr_out      <= '0;
            phy_enable_out    <= 1'b0;
            pixel_top_out     <= '0;
            pixel_bot_out     <= '0;
            latch_enable_out  <= 1'b0;
            output_enable_out <= 1'b1;
            addr_out          <= '0;
            busy_out          <= 1'b0;
            frame_done_out    <= 1'b0;
        end else begin
            // single-cycle strobes default low; set only on the edge entering their cycle
            ram_en_out       <= 1'b0;
            phy_enable_out   <= 1'b0;
            latch_enable_out <= 1'b0;
            frame_done_out   <= 1'b0;
            case (state)
                IDLE: if (enable_in) begin
                    state        <= FETCH_TOP;
                    busy_out     <= 1'b1;
                    col          <= '0;
                    row          <= '0;
                    ram_en_out   <= 1'b1;
                    ram_addr_out <= pix_addr(0, 0);
                end
                FETCH_TOP: begin
                    state <= WAIT_TOP;
                    dly   <= '0;
                end
                WAIT_TOP: if (dly == DLY_W'(RAM_LATENCY - 1)) begin
                    pixel_top_out <= ram_data_in;
                    state         <= FETCH_BOT;
                    ram_en_out    <= 1'b1;
                    ram_addr_out  <= pix_addr(int'(row) + HALF, int'(col));
                end else begin
                    dly <= dly + DLY_W'(1);
                end
                FETCH_BOT: begin
                    state <= WAIT_BOT;
                    dly   <= '0;
                end
                WAIT_BOT: if (dly == DLY_W'(RAM_LATENCY - 1)) begin
                    pixel_bot_out <= ram_data_in;
                    state         <= SEND;
                end else begin
                    dly <= dly + DLY_W'(1);
                end
                SEND: if (phy_ready_in) begin
                    phy_enable_out <= 1'b1;
                    state          <= WAIT_PHY;
                    dly            <= '0;
                end
                // ready is stale during the pulse cycle and the one after it
                WAIT_PHY: if (dly < DLY_W'(2)) begin
                    dly <= dly + DLY_W'(1);
                end else if (phy_ready_in) begin
                    dly <= '0;
                    if (col == COL_W'(NUM_COLS - 1)) begin
                        state <= BLANK;
                    end else begin
                        col          <= col + COL_W'(1);
                        state        <= FETCH_TOP;
                        ram_en_out   <= 1'b1;
                        ram_addr_out <= pix_addr(int'(row), int'(col) + 1);
                    end
                end
                BLANK: if (dly == DLY_W'(BLANK_CYCLES - 1)) begin
                    state            <= LATCH;
                    latch_enable_out <= 1'b1;
                    addr_out         <= row;
                end else begin
                    dly <= dly + DLY_W'(1);
                end
                LATCH: begin
                    state <= UNBLANK;
                    dly   <= '0;
                end
                UNBLANK: if (dly == DLY_W'(BLANK_CYCLES - 1)) begin
                    state             <= DISPLAY;
                    output_enable_out <= 1'b0;
                    dly               <= '0;
                end else begin
                    dly <= dly + DLY_W'(1);
                end
                DISPLAY: if (dly == DLY_W'(DISPLAY_CYCLES - 1)) begin
                    output_enable_out <= 1'b1;
                    col               <= '0;
                    dly               <= '0;
                    if (row == ROW_ADDR_W'(HALF - 1)) begin
                        row            <= '0;
                        frame_done_out <= 1'b1;
                        if (enable_in) begin
                            state        <= FETCH_TOP;
                            ram_en_out   <= 1'b1;
                            ram_addr_out <= pix_addr(0, 0);
                        end else begin
                            state    <= IDLE;
                            busy_out <= 1'b0;
                        end
                    end else begin
                        row          <= row + ROW_ADDR_W'(1);
                        state        <= FETCH_TOP;
                        ram_en_out   <= 1'b1;
                        ram_addr_out <= pix_addr(int'(row) + 1, 0);
                    end
                end else begin
                    dly <= dly + DLY_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Bench for frame_scan_ctrl: RAM holding word i at address i, PHY with a
// programmable busy time, and a pixel-pair scoreboard filled per frame.
module tb_frame_scan_ctrl;
    localparam int NR = 32, NC = 64, L = 2, B = 4, D = 256, HALF = 16, RW = 4;

    logic        clk = 1'b0;
    logic        reset_in, enable_in;
    logic        ram_en_out;
    logic [15:0] ram_addr_out;
    logic [23:0] ram_data_in;
    logic        phy_enable_out;
    logic        phy_ready_in = 1'b1;
    logic [23:0] pixel_top_out, pixel_bot_out;
    logic        latch_enable_out, output_enable_out;
    logic [RW-1:0] addr_out;
    logic        busy_out, frame_done_out;

    always #5 clk = ~clk;

    frame_scan_ctrl #(
        .NUM_ROWS(NR), .NUM_COLS(NC), .RAM_LATENCY(L),
        .BLANK_CYCLES(B), .DISPLAY_CYCLES(D), .ROW_ADDR_W(RW)
    ) dut (
        .clk_in(clk), .reset_in(reset_in), .enable_in(enable_in),
        .ram_en_out(ram_en_out), .ram_addr_out(ram_addr_out), .ram_data_in(ram_data_in),
        .phy_enable_out(phy_enable_out), .phy_ready_in(phy_ready_in),
        .pixel_top_out(pixel_top_out), .pixel_bot_out(pixel_bot_out),
        .latch_enable_out(latch_enable_out), .output_enable_out(output_enable_out),
        .addr_out(addr_out), .busy_out(busy_out), .frame_done_out(frame_done_out)
    );

    // RAM: data valid for exactly one cycle, L clocks after the read enable
    logic [23:0] rd_s1 = 24'hBADBAD, rd_s2 = 24'hBADBAD;
    always @(posedge clk) begin
        rd_s1 <= ram_en_out ? {8'h00, ram_addr_out} : 24'hBADBAD;
        rd_s2 <= rd_s1;
    end
    assign ram_data_in = rd_s2;

    // PHY: drops ready for phy_busy cycles after each enable pulse
    int phy_busy = 10;
    int phy_cnt  = 0;
    always @(posedge clk) begin
        if (phy_enable_out) begin
            phy_ready_in <= 1'b0;
            phy_cnt      <= phy_busy;
        end else if (!phy_ready_in) begin
            if (phy_cnt <= 1) phy_ready_in <= 1'b1;
            else              phy_cnt <= phy_cnt - 1;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL timeout_%s: DUT event not seen within cycle budget at %0t", name, $time);
    endtask

    logic [23:0] q_top[$], q_bot[$];

    task automatic push_frame();
        for (int r = 0; r < HALF; r++)
            for (int c = 0; c < NC; c++) begin
                q_top.push_back(24'(r * NC + c));
                q_bot.push_back(24'((r + HALF) * NC + c));
            end
    endtask

    // outputs seen at a negedge reflect the inputs sampled at the preceding posedge
    logic rst_seen = 1'b1, en_q = 1'b0;
    always @(posedge clk) begin
        rst_seen <= reset_in;
        en_q     <= enable_in;
    end

    int exp_row, pulses_row, pulses_frame, pulses_total = 0, reads_frame, reads_total = 0;
    int frames_done = 0, oe_low, oe_high, since_le;
    logic expect_addr0, hold, le_armed, prev_le, prev_pe;
    logic [RW-1:0] prev_addr;
    logic [23:0] held_top, held_bot, last_top, last_bot, exp_t, exp_b;

    always @(negedge clk) begin
        if (rst_seen) begin
            q_top.delete(); q_bot.delete();
            exp_row = 0; pulses_row = 0; pulses_frame = 0; reads_frame = 0;
            expect_addr0 = 1'b1; hold = 1'b0; le_armed = 1'b0;
            oe_low = 0; oe_high = 0; since_le = 0;
            prev_le = 1'b0; prev_pe = 1'b0; prev_addr = '0;
        end else begin
            if (frame_done_out) begin
                chk("frame_rows", exp_row, HALF);
                chk("frame_reads", reads_frame, 2 * NC * HALF);
                chk("last_top", last_top, 24'h0003FF);
                chk("last_bot", last_bot, 24'h0007FF);
                frames_done++;
                exp_row = 0; reads_frame = 0; pulses_frame = 0; expect_addr0 = 1'b1;
                if (en_q) push_frame();
            end
            if (ram_en_out) begin
                if (expect_addr0) begin
                    chk("first_read_addr", ram_addr_out, 0);
                    expect_addr0 = 1'b0;
                end
                reads_frame++;
                reads_total++;
            end
            if (hold) begin
                if (phy_ready_in) hold = 1'b0;
                else begin
                    chk("hold_top", pixel_top_out, held_top);
                    chk("hold_bot", pixel_bot_out, held_bot);
                end
            end
            if (phy_enable_out) begin
                chk("pulse_ready", phy_ready_in, 1);
                chk("pulse_width", prev_pe, 0);
                if (q_top.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL sb_empty: pulse with top=0x%0h, expected no pulse", pixel_top_out);
                end else begin
                    exp_t = q_top.pop_front();
                    exp_b = q_bot.pop_front();
                    chk("pix_top", pixel_top_out, exp_t);
                    chk("pix_bot", pixel_bot_out, exp_b);
                end
                if (pulses_frame == 0) begin
                    chk("first_top", pixel_top_out, 24'h000000);
                    chk("first_bot", pixel_bot_out, 24'h000400);
                end
                last_top = pixel_top_out; last_bot = pixel_bot_out;
                held_top = pixel_top_out; held_bot = pixel_bot_out;
                hold = 1'b1;
                pulses_row++; pulses_frame++; pulses_total++;
            end
            if (latch_enable_out) begin
                chk("le_addr", addr_out, exp_row);
                chk("le_width", prev_le, 0);
                chk("le_oe", output_enable_out, 1);
                chk("le_blank_before", oe_high >= B, 1);
                chk("le_pulses_row", pulses_row, NC);
                exp_row++; pulses_row = 0; le_armed = 1'b1; since_le = 0;
            end else begin
                chk("addr_hold", addr_out, prev_addr);
            end
            if (!output_enable_out) begin
                if (le_armed) begin
                    chk("unblank_len", since_le, B);
                    le_armed = 1'b0;
                end
                oe_low++;
                oe_high = 0;
            end else begin
                if (oe_low != 0) begin
                    chk("display_len", oe_low, D);
                    oe_low = 0;
                end
                oe_high++;
                if (le_armed && !latch_enable_out) since_le++;
            end
            prev_le = latch_enable_out; prev_pe = phy_enable_out; prev_addr = addr_out;
        end
    end

    typedef struct {
        logic rst; logic en;
        logic busy; logic oe; logic ram_en; logic [15:0] ram_addr;
        logic [RW-1:0] addr; logic [23:0] pix;
    } vec_t;
    vec_t vecs[4];

    initial begin
        int k, snap_reads, p0;
        reset_in = 1'b1;
        enable_in = 1'b0;
        vecs[0] = '{rst: 1'b1, en: 1'b0, busy: 1'b0, oe: 1'b1, ram_en: 1'b0, ram_addr: 16'h0, addr: '0, pix: 24'h0};
        vecs[1] = '{rst: 1'b1, en: 1'b1, busy: 1'b0, oe: 1'b1, ram_en: 1'b0, ram_addr: 16'h0, addr: '0, pix: 24'h0};
        vecs[2] = '{rst: 1'b0, en: 1'b0, busy: 1'b0, oe: 1'b1, ram_en: 1'b0, ram_addr: 16'h0, addr: '0, pix: 24'h0};
        vecs[3] = '{rst: 1'b0, en: 1'b1, busy: 1'b1, oe: 1'b1, ram_en: 1'b1, ram_addr: 16'h0, addr: '0, pix: 24'h0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].en && !vecs[i].rst) push_frame();
            reset_in  = vecs[i].rst;
            enable_in = vecs[i].en;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), busy_out, vecs[i].busy);
            chk($sformatf("vec%0d_oe", i), output_enable_out, vecs[i].oe);
            chk($sformatf("vec%0d_ram_en", i), ram_en_out, vecs[i].ram_en);
            chk($sformatf("vec%0d_ram_addr", i), ram_addr_out, vecs[i].ram_addr);
            chk($sformatf("vec%0d_addr", i), addr_out, vecs[i].addr);
            chk($sformatf("vec%0d_pix_top", i), pixel_top_out, vecs[i].pix);
            chk($sformatf("vec%0d_pix_bot", i), pixel_bot_out, vecs[i].pix);
            chk($sformatf("vec%0d_phy_en", i), phy_enable_out, 0);
            chk($sformatf("vec%0d_le", i), latch_enable_out, 0);
            chk($sformatf("vec%0d_done", i), frame_done_out, 0);
        end

        // full frame with enable held high, which restarts at row 0
        for (k = 0; k < 40000 && !frame_done_out; k++) @(negedge clk);
        if (!frame_done_out) timeout("frame1");

        // reset in the middle of row 5's display period
        for (k = 0; k < 40000 && !(addr_out == 4'd5 && !output_enable_out); k++) @(negedge clk);
        if (!(addr_out == 4'd5 && !output_enable_out)) timeout("row5_display");
        repeat (20) @(negedge clk);
        reset_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_oe", output_enable_out, 1);
        chk("rst_addr", addr_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_ram_en", ram_en_out, 0);
        chk("rst_le", latch_enable_out, 0);
        chk("rst_pix_top", pixel_top_out, 0);
        reset_in = 1'b0;
        @(posedge clk);
        #1 push_frame();

        // drop enable once row 3 has been displayed; the frame still completes
        for (k = 0; k < 40000 && addr_out != 4'd4; k++) @(negedge clk);
        if (addr_out != 4'd4) timeout("row4_latch");
        enable_in = 1'b0;
        for (k = 0; k < 40000 && !frame_done_out; k++) @(negedge clk);
        if (!frame_done_out) timeout("frame_after_drop");
        @(negedge clk);
        snap_reads = reads_total;
        repeat (300) @(negedge clk);
        chk("idle_busy", busy_out, 0);
        chk("idle_oe", output_enable_out, 1);
        chk("idle_reads", reads_total - snap_reads, 0);
        chk("sb_drained", q_top.size(), 0);
        chk("frames_done", frames_done, 2);

        // slow PHY: SEND stalls, one pulse per column, pixels held
        phy_busy = 1000;
        p0 = pulses_total;
        push_frame();
        enable_in = 1'b1;
        for (k = 0; k < 10000 && pulses_total < p0 + 3; k++) @(negedge clk);
        if (pulses_total < p0 + 3) timeout("slow_phy");
        repeat (500) @(negedge clk);
        chk("slow_pulses", pulses_total - p0, 3);
        reset_in = 1'b1;
        enable_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("final_rst_busy", busy_out, 0);
        reset_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("final_idle_busy", busy_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_scan_ctrl.md
# frame_scan_ctrl

Sequencer between the 24-bit frame RAM and the display PHY. It walks the frame buffer one row pair at a time, fetching the top-half and bottom-half pixel of each column. Each pair goes to the PHY over its enable/ready handshake. After every row it blanks the panel, latches the row and selects the next row address. It replaces the fixed-colour path of the display driver as the pixel source for the panel outputs.

## Interface
Parameters:
- NUM_ROWS, 32, panel rows (even); NUM_ROWS/2 row pairs are scanned.
- NUM_COLS, 64, panel columns.
- RAM_LATENCY, 2, clocks from ram_en_out/ram_addr_out to valid ram_data_in.
- BLANK_CYCLES, 4, clocks OE held inactive before and after LE.
- DISPLAY_CYCLES, 256, clocks OE active per row.
- ROW_ADDR_W, $clog2(NUM_ROWS/2), width of addr_out.

Ports:
- clk_in  in  1  system clock; single clock domain.
- reset_in  in  1  synchronous, active-high reset.
- enable_in  in  1  level; scanning runs while high.
- ram_en_out  out  1  RAM read enable, one-cycle pulse per read.
- ram_addr_out  out  16  RAM word address.
- ram_data_in  in  24  RAM read data.
- phy_enable_out  out  1  one-cycle start pulse to the PHY.
- phy_ready_in  in  1  PHY idle/ready.
- pixel_top_out  out  24  top-half pixel, held stable from the enable pulse until ready returns.
- pixel_bot_out  out  24  bottom-half pixel, same hold rule.
- latch_enable_out  out  1  row latch pulse.
- output_enable_out  out  1  high = panel blanked.
- addr_out  out  ROW_ADDR_W  displayed row-pair address.
- busy_out  out  1  high in any state other than IDLE.
- frame_done_out  out  1  one-cycle pulse after the last row's display period.

## Operation
- State machine: IDLE → FETCH_TOP → WAIT_TOP → FETCH_BOT → WAIT_BOT → SEND → WAIT_PHY → (next column: FETCH_TOP) or, after the last column, BLANK → LATCH → UNBLANK → DISPLAY → (next row: FETCH_TOP) or IDLE.
- Counters:
  - col (0..NUM_COLS-1).
  - row (0..NUM_ROWS/2-1).
  - a shared delay counter for RAM wait, blank and display timing.
- Addressing: top = row*NUM_COLS + col; bottom = (row + NUM_ROWS/2)*NUM_COLS + col. Computed at full width and truncated to 16 bits.
- FETCH_x: ram_en_out=1 for one cycle with the address.
- WAIT_x: count RAM_LATENCY cycles, then register ram_data_in into the pixel_x register.
- SEND: entered only when phy_ready_in=1, otherwise wait in SEND. Drive phy_enable_out=1 for exactly one cycle.
- WAIT_PHY:
  - Ignore phy_ready_in on the first cycle after the pulse.
  - Then leave on the first cycle phy_ready_in=1.
  - Increment col on exit.
- Output enable: OE is 0 only in DISPLAY. It is 1 everywhere else, including while shifting the next row.
- BLANK: BLANK_CYCLES cycles.
- LATCH: one cycle with latch_enable_out=1. addr_out updates to the current row in the same cycle.
- UNBLANK: BLANK_CYCLES cycles.
- DISPLAY: DISPLAY_CYCLES cycles with OE=0. Then row increments (wraps to 0 after NUM_ROWS/2-1) and col resets to 0.
- Last row exit: frame_done_out pulses on the DISPLAY exit cycle. If enable_in=1, continue directly with row 0 at FETCH_TOP; else go to IDLE.
- enable_in deassert mid-frame: the current frame completes, then the block goes IDLE. enable_in is sampled only in IDLE and at frame end.
- IDLE → FETCH_TOP on the first cycle enable_in=1. Every frame starts at row 0, col 0.
- No write access to the RAM from this block; ram_en_out is used for reads only.

## Timing
- Reset (synchronous, takes effect at the clock edge with reset_in=1, from any state including mid-row):
  - state=IDLE, counters=0, ram_en_out=0, ram_addr_out=0, phy_enable_out=0.
  - pixel_top_out/pixel_bot_out=0, latch_enable_out=0, output_enable_out=1, addr_out=0, busy_out=0, frame_done_out=0.
- Fetch latency: from FETCH_TOP to the pixels registered is 2*(RAM_LATENCY+1) cycles (6 at default). SEND follows on the next cycle.
- Per-pixel time: 2*(RAM_LATENCY+1) + 1 + PHY busy time.
- Per-row overhead after the last column: 2*BLANK_CYCLES + 1 + DISPLAY_CYCLES (265 at default).
- Pixel outputs change only in WAIT_x capture cycles, never while the PHY is busy.
- Simultaneous events:
  - phy_ready_in=0 in SEND: the block stalls with no pulse.
  - reset_in=1 with enable_in=1: reset wins.

## Test plan
- Reset mid-DISPLAY of row 5 → next cycle OE=1, addr_out=0, busy=0. On release with enable=1, the first RAM read is at addr 0.
- RAM preloaded with word i at address i, PHY model ready after 10 cycles:
  - Column 0 of row 0 → pixel_top=0x000000, pixel_bot=0x000400 (16*64).
  - Column 63 of row 15 → pixel_top=0x0003FF, pixel_bot=0x0007FF.
- PHY model holds ready low for 1000 cycles → exactly one phy_enable pulse per column, pixels stable throughout, 64 pulses per row.
- Row boundary: OE rises before LE; LE is a single cycle; addr_out changes with LE. OE=0 for exactly 256 cycles with BLANK_CYCLES=4 gaps on both sides.
- Full frame: 16 LE pulses, addr_out 0..15, then frame_done pulses once. With enable held high, scanning restarts at address 0.
- enable_in dropped after row 3 → the frame completes through row 15, frame_done pulses, the block goes IDLE with OE=1 and no further RAM reads.
